score_display: RTL
==================

// Module: score_display
// PURPOSE
// - Drives the 4-digit multiplexed 7-segment score display from a binary score.
// - Converts the score to BCD with a sequential double-dabble engine.
// - Scans one digit per rising edge of segclk, which comes from the clock divider.
// - Sits directly downstream of the clock divider and beside the game-logic score counter.
// PARAMETERS
// - SCORE_W  14  width of the binary score input; values above 9999 saturate to 9999
// - LZ_BLANK 0   1 = blank leading-zero digits (digit 0 is never blanked)
// PORTS
// - clk     in   1        master clock, 50 MHz
// - clr     in   1        reset, synchronous, active-high
// - segclk  in   1        digit-scan clock from the divider (~381 Hz); sampled as data, never used as a clock
// - score   in   SCORE_W  binary score to show
// - load    in   1        1-cycle strobe: capture score and start conversion
// - busy    out  1        conversion in progress
// - seg     out  7        active-low segments; seg[6]=a ... seg[0]=g
// - an      out  4        active-low digit anodes; an[0]=rightmost (ones)
// - dp      out  1        active-low decimal point; constant 1 (off)
// - blink   in   1        present only with SEG_BLINK_EN
// BEHAVIOUR
// - Single clock domain (clk). Reset is synchronous, active-high, on clr.
// - Values after reset:
//   - seg = 7'b1111111, an = 4'b1111, dp = 1, busy = 0.
//   - Display BCD register = 0. Scan index = 3. FSM = IDLE.
// - segclk input path:
//   - 2-FF synchronizer, then rising-edge detect.
//   - Each detected edge advances the scan index: 3 -> 0 -> 1 -> 2 -> 3 (wraps).
//   - The first edge after reset therefore selects digit 0.
// - Scan outputs:
//   - an and seg are registered and update on the same clk edge that advances the index.
//   - an = ~(4'b0001 << idx). seg = decode(display nibble idx).
// - Decode table (active-low abcdefg):
//   - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
//   - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
//   - Nibbles 10-15 never occur; if present they decode to blank 1111111.
// - LZ_BLANK=1: a digit d>0 shows blank when it and every higher digit are 0.
// - Conversion FSM, states IDLE, SHIFT, DONE:
//   - IDLE: load=1 captures min(score, 9999), clears the BCD accumulator, sets shift count = SCORE_W, busy = 1 -> SHIFT.
//   - SHIFT: per cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 and decrement the count; count reaches 0 -> DONE.
//   - DONE: copy the 16-bit BCD into the display register, busy = 0 -> IDLE.
// - Latency: load sampled at edge N -> busy=1 from N; display register and busy=0 at edge N+SCORE_W+1.
// - load while busy (SHIFT or DONE) is ignored; it is not queued.
// - Display register update and scan edge on the same cycle: the scan uses the old value; the new value appears from the next scan edge.
// - clr asserted mid-conversion aborts to IDLE; the display returns to 0.
// CONFIGURATION
// - Macro SEG_BLINK_EN:
//   - Defined: the blink port exists; blink=1 forces an=4'b1111 combinationally after the register (seg unaffected); scan index and conversion keep running.
//   - Undefined: no blink port; an comes straight from its register.
// STRUCTURE
// - Package seg_pkg:
//   - NUM_DIGITS=4, BCD_W=16, SCORE_MAX=9999.
//   - SEG_BLANK, plus the SEG_DIGIT[0:9] decode constants.
//   - Conversion FSM state typedef.
// - One sub-module, bin2bcd: the double-dabble FSM.
//   - Ports: clk, clr, start, bin, busy, bcd, done.
//   - score_display owns the synchronizer, scan, decode and blink logic.
// TESTING
// - Reset: assert clr for 2 cycles -> an=1111, seg=1111111, dp=1, busy=0; first segclk edge -> an=1110, seg=0000001.
// - load with score=1234 (SCORE_W=14) -> busy high exactly 15 cycles; four segclk edges -> an=1110 seg=1001100, an=1101 seg=0000110, an=1011 seg=0010010, an=0111 seg=1001111.
// - score=16383 -> all four digits show 9 (0000100).
// - load=1234, then load=5678 two cycles later -> second load ignored; display shows 1234.
// - LZ_BLANK=1, score=7 -> digit0 = 0001111; digits 1-3 = 1111111. With score=0, digit0 = 0000001.
// - SEG_BLINK_EN defined, blink=1 for 3 scan edges -> an=1111 throughout; blink=0 -> scan resumes at the correct next digit. Also: clr mid-SHIFT -> busy=0 next cycle and display=0.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants, types and helpers for the score display.
//   NUM_DIGITS / BCD_W / SCORE_MAX : display geometry and saturation limit
//   SEG_BLANK / SEG_DIGIT          : active-low abcdefg patterns (bit 6 = a)
//   conv_state_t                   : double-dabble conversion FSM states
//   seg_decode()                   : BCD nibble -> segment pattern
//   dabble_adj()                   : per-nibble "add 3 if >= 5" correction
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 16;
    localparam int SCORE_MAX  = 9999;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Non-decimal nibbles cannot come out of the converter; show them blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_DIGIT[0];
            4'd1:    pat = SEG_DIGIT[1];
            4'd2:    pat = SEG_DIGIT[2];
            4'd3:    pat = SEG_DIGIT[3];
            4'd4:    pat = SEG_DIGIT[4];
            4'd5:    pat = SEG_DIGIT[5];
            4'd6:    pat = SEG_DIGIT[6];
            4'd7:    pat = SEG_DIGIT[7];
            4'd8:    pat = SEG_DIGIT[8];
            4'd9:    pat = SEG_DIGIT[9];
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Inputs above SCORE_MAX saturate to SCORE_MAX before conversion.
//   clk   in  1        clock
//   clr   in  1        synchronous active-high reset (aborts a conversion)
//   start in  1        strobe; accepted only while idle
//   bin   in  SCORE_W  binary value, captured on an accepted start
//   busy  out 1        registered; high from the accepting edge until the
//                      edge that leaves DONE
//   bcd   out BCD_W    conversion accumulator (final once done is high)
//   done  out 1        high during the DONE cycle; the consumer copies bcd
// -----------------------------------------------------------------------------
module bin2bcd
    import seg_pkg::*;
#(
    parameter int SCORE_W = 14
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);

    localparam int CNT_W = $clog2(SCORE_W + 1);

    conv_state_t        state_r;
    conv_state_t        state_s;
    logic [SCORE_W-1:0] bin_r;
    logic [BCD_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic [BCD_W-1:0]   adj_s;
    logic [SCORE_W-1:0] sat_s;
    logic               load_s;
    logic               shift_s;
    logic               finish_s;

    // Clamp the incoming value to the largest displayable score.
    always_comb begin
        if (32'(bin) > SCORE_MAX) begin
            sat_s = SCORE_W'(SCORE_MAX);
        end else begin
            sat_s = bin;
        end
    end

    // Add-3 correction of every BCD nibble ahead of the shift.
    always_comb begin
        adj_s = acc_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj_s[4*i +: 4] = dabble_adj(acc_r[4*i +: 4]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; the SHIFT cycle with count 1 performs the last shift.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        load_s   = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE:    load_s   = start;
            SHIFT:   shift_s  = 1'b1;
            DONE:    finish_s = 1'b1;
            default: begin
                load_s   = 1'b0;
                shift_s  = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Conversion datapath: capture, then shift {bcd, bin} left once per cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_r <= '0;
            bin_r <= '0;
            cnt_r <= '0;
        end else if (load_s) begin
            acc_r <= '0;
            bin_r <= sat_s;
            cnt_r <= CNT_W'(SCORE_W);
        end else if (shift_s) begin
            {acc_r, bin_r} <= {adj_s, bin_r} << 1;
            cnt_r          <= cnt_r - CNT_W'(1);
        end else begin
            acc_r <= acc_r;
            bin_r <= bin_r;
            cnt_r <= cnt_r;
        end
    end

    // Busy flag: set on acceptance, cleared on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (clr) begin
            busy_r <= 1'b0;
        end else if (load_s) begin
            busy_r <= 1'b1;
        end else if (finish_s) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= busy_r;
        end
    end

    assign busy = busy_r;
    assign bcd  = acc_r;
    assign done = finish_s;

endmodule

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
// Drives a 4-digit multiplexed active-low 7-segment display from a binary
// score. The score is converted to BCD by bin2bcd; one digit is scanned per
// rising edge of segclk, which is synchronised and treated purely as data.
// Optional feature macro: SEG_BLINK_EN adds the blink input, which blanks all
// anodes after the anode register while scanning and conversion continue.
//   clk    in  1        master clock
//   clr    in  1        synchronous active-high reset
//   segclk in  1        digit-scan tick from the clock divider (data input)
//   score  in  SCORE_W  binary score
//   load   in  1        strobe: capture score and start conversion
//   blink  in  1        (SEG_BLINK_EN only) 1 = all anodes off
//   busy   out 1        conversion in progress
//   seg    out 7        active-low segments, seg[6]=a ... seg[0]=g
//   an     out 4        active-low anodes, an[0] = ones digit
//   dp     out 1        active-low decimal point, always off
// -----------------------------------------------------------------------------
module score_display
    import seg_pkg::*;
#(
    parameter int SCORE_W  = 14,
    parameter int LZ_BLANK = 0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               segclk,
    input  logic [SCORE_W-1:0] score,
    input  logic               load,
`ifdef SEG_BLINK_EN
    input  logic               blink,
`endif
    output logic               busy,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               dp
);

    logic [2:0]            sync_r;
    logic                  scan_edge_s;
    logic [1:0]            idx_r;
    logic [1:0]            idx_next_s;
    logic [BCD_W-1:0]      bcd_s;
    logic                  conv_done_s;
    logic [BCD_W-1:0]      disp_r;
    logic [3:0]            nib_s;
    logic                  zero_run_s;
    logic [NUM_DIGITS-1:0] hi_zero_s;
    logic [6:0]            seg_next_s;
    logic [3:0]            an_next_s;
    logic [6:0]            seg_r;
    logic [3:0]            an_r;
    logic                  dp_r;

    bin2bcd #(
        .SCORE_W (SCORE_W)
    ) u_bin2bcd (
        .clk   (clk),
        .clr   (clr),
        .start (load),
        .bin   (score),
        .busy  (busy),
        .bcd   (bcd_s),
        .done  (conv_done_s)
    );

    // Two-stage synchroniser for segclk plus one history stage for edge detect.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], segclk};
        end
    end

    assign scan_edge_s = sync_r[1] & ~sync_r[2];

    // Display register: takes the finished BCD value during the DONE cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            disp_r <= '0;
        end else if (conv_done_s) begin
            disp_r <= bcd_s;
        end else begin
            disp_r <= disp_r;
        end
    end

    // Digit about to be shown; 3 wraps to 0 naturally in two bits.
    always_comb begin
        idx_next_s = idx_r + 2'd1;
        nib_s      = disp_r[{idx_next_s, 2'b00} +: 4];
        an_next_s  = ~(4'b0001 << idx_next_s);
    end

    // hi_zero_s[d] is set when digit d and every digit above it are zero.
    always_comb begin
        zero_run_s = 1'b1;
        hi_zero_s  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s   = zero_run_s & (disp_r[4*i +: 4] == 4'd0);
            hi_zero_s[i] = zero_run_s;
        end
    end

    // Segment pattern for the next digit, with optional leading-zero blanking.
    always_comb begin
        if ((LZ_BLANK != 0) && (idx_next_s != 2'd0) && hi_zero_s[idx_next_s]) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = seg_decode(nib_s);
        end
    end

    // Scan registers: index, anodes and segments all move on a detected edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            idx_r <= 2'd3;
            an_r  <= 4'b1111;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            dp_r <= 1'b1;
            if (scan_edge_s) begin
                idx_r <= idx_next_s;
                an_r  <= an_next_s;
                seg_r <= seg_next_s;
            end else begin
                idx_r <= idx_r;
                an_r  <= an_r;
                seg_r <= seg_r;
            end
        end
    end

`ifdef SEG_BLINK_EN
    assign an = blink ? 4'b1111 : an_r;
`else
    assign an = an_r;
`endif
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule
